// File: rtl/eth_rx_pkg.sv
// Shared receive-path definitions: FSM encoding, SFD, CRC constants, status bits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eth_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_BODY     = 3'd2,
      ST_DROP     = 3'd3,
      ST_END      = 3'd4
   } rx_state_t;

   localparam logic [7:0]  SFD           = 8'hD5;
   localparam logic [31:0] CRC_PRESET    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;   // 04C11DB7 bit-reversed
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;   // register value after data+FCS

   // Status byte layout, written as the last FIFO entry of a frame.
   localparam int ST_FCS_OK_BIT  = 7;
   localparam int ST_LEN_OK_BIT  = 6;
   localparam int ST_DRIBBLE_BIT = 5;
   localparam int ST_ABORTED_BIT = 4;

   function automatic logic [7:0] status_byte(input logic fcs_ok, input logic len_ok,
                                              input logic dribble, input logic aborted);
      logic [7:0] s;
      s                 = 8'h00;
      s[ST_FCS_OK_BIT]  = fcs_ok;
      s[ST_LEN_OK_BIT]  = len_ok;
      s[ST_DRIBBLE_BIT] = dribble;
      s[ST_ABORTED_BIT] = aborted;
      return s;
   endfunction

endpackage

// File: rtl/eth_bin2gray.sv
// Binary to gray-code converter for counters read from another clock domain.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: bin (binary value), gray (gray-coded value).
module eth_bin2gray #(
   parameter int W = 16
) (
   input  logic [W-1:0] bin,
   output logic [W-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/eth_crc32_step.sv
// Combinational reflected CRC-32 update over W input bits, bit 0 first.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: crc_in (current register), data (W new bits), crc_out (updated register).
module eth_crc32_step
   import eth_rx_pkg::*;
#(
   parameter int W = 2
) (
   input  logic [31:0]  crc_in,
   input  logic [W-1:0] data,
   output logic [31:0]  crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in;
      for (int i = 0; i < W; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
         else                c = c >> 1;
      end
      crc_out = c;
   end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII/MII receive framer: strips preamble/SFD, writes frame bytes plus a trailing status byte.
// Latency: a byte is written 1 cycle after its last bit is sampled; status 1 cycle after END.
// Backpressure: fifo_afull on a byte boundary aborts the frame (rest dropped, overflow counted).
// Ports: REF_CLK/arst_n; CRS/RXD wire input; fifo_afull in, fifo_din/fifo_wren/fifo_EOD_in out;
//        three gray-coded monitor counters (good frames, overflows, FCS errors).
module rmii_rx_framer
   import eth_rx_pkg::*;
#(
   parameter int DIN_W   = 2,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16
) (
   input  logic             REF_CLK,
   input  logic             arst_n,
   input  logic             CRS,
   input  logic [DIN_W-1:0] RXD,
   input  logic             fifo_afull,
   output logic [7:0]       fifo_din,
   output logic             fifo_wren,
   output logic             fifo_EOD_in,
   output logic [CNT_W-1:0] succ_rx_count_gray,
   output logic [CNT_W-1:0] buff_OF_count_gray,
   output logic [CNT_W-1:0] fcs_err_count_gray
);

   localparam int         NSTEP   = 8 / DIN_W;
   localparam logic [1:0] PH_LAST = 2'(NSTEP - 1);
   localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
   localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

   rx_state_t        state;
   logic [7:0]       sr;
   logic [7:0]       sr_nxt;
   logic [1:0]       phase;
   logic [31:0]      crc;
   logic [31:0]      crc_byte;
   logic [10:0]      byte_cnt;
   logic             dribble;
   logic             aborted;
   logic             no_status;
   logic             armed;
   logic [CNT_W-1:0] succ_cnt;
   logic [CNT_W-1:0] of_cnt;
   logic [CNT_W-1:0] fcs_cnt;
   logic             fcs_ok;
   logic             len_ok;
   logic             byte_done;

   // Newest bits enter at the top, so after 8/DIN_W cycles bit 0 is the earliest wire bit.
   assign sr_nxt    = {RXD, sr[7:DIN_W]};
   assign byte_done = (phase == PH_LAST);
   assign fcs_ok    = (crc == CRC_RESIDUE);
   assign len_ok    = (byte_cnt >= LEN_MIN) && (byte_cnt <= LEN_MAX);

   // CRC advances only on whole bytes so trailing dribble bits never reach it.
   logic [31:0] crc_chain [NSTEP+1];
   assign crc_chain[0] = crc;
   assign crc_byte     = crc_chain[NSTEP];

   for (genvar k = 0; k < NSTEP; k++) begin : g_crc
      eth_crc32_step #(.W(DIN_W)) u_step (
         .crc_in  (crc_chain[k]),
         .data    (sr_nxt[k*DIN_W +: DIN_W]),
         .crc_out (crc_chain[k+1])
      );
   end

   always_ff @(posedge REF_CLK or negedge arst_n) begin
      if (!arst_n) begin
         state       <= ST_IDLE;
         sr          <= 8'h00;
         phase       <= 2'd0;
         crc         <= 32'h0;
         byte_cnt    <= 11'd0;
         dribble     <= 1'b0;
         aborted     <= 1'b0;
         no_status   <= 1'b0;
         armed       <= 1'b0;
         succ_cnt    <= '0;
         of_cnt      <= '0;
         fcs_cnt     <= '0;
         fifo_din    <= 8'h00;
         fifo_wren   <= 1'b0;
         fifo_EOD_in <= 1'b0;
      end else begin
         sr          <= sr_nxt;
         fifo_wren   <= 1'b0;
         fifo_EOD_in <= 1'b0;
         // A frame already running when reset released is ignored until carrier drops once.
         if (!CRS) armed <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (CRS && armed) begin
                  dribble <= 1'b0;
                  aborted <= 1'b0;
                  if (fifo_afull) begin
                     state     <= ST_DROP;
                     no_status <= 1'b1;
                     of_cnt    <= of_cnt + 1'b1;
                  end else begin
                     state     <= ST_PREAMBLE;
                     no_status <= 1'b0;
                  end
               end
            end

            ST_PREAMBLE: begin
               if (!CRS) begin
                  state <= ST_IDLE;
               end else if (sr_nxt == SFD) begin
                  state    <= ST_BODY;
                  phase    <= 2'd0;
                  crc      <= CRC_PRESET;
                  byte_cnt <= 11'd0;
               end
            end

            ST_BODY: begin
               if (!CRS) begin
                  dribble <= (phase != 2'd0);
                  state   <= ST_END;
               end else if (byte_done) begin
                  phase <= 2'd0;
                  if (fifo_afull) begin
                     aborted <= 1'b1;
                     of_cnt  <= of_cnt + 1'b1;
                     state   <= ST_DROP;
                  end else begin
                     fifo_wren <= 1'b1;
                     fifo_din  <= sr_nxt;
                     crc       <= crc_byte;
                     if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
                  end
               end else begin
                  phase <= phase + 2'd1;
               end
            end

            ST_DROP: begin
               if (!CRS) state <= no_status ? ST_IDLE : ST_END;
            end

            ST_END: begin
               fifo_wren   <= 1'b1;
               fifo_EOD_in <= 1'b1;
               fifo_din    <= status_byte(fcs_ok, len_ok, dribble, aborted);
               if (fcs_ok && len_ok && !dribble && !aborted) succ_cnt <= succ_cnt + 1'b1;
               if (!fcs_ok && !aborted)                      fcs_cnt  <= fcs_cnt + 1'b1;
               state <= ST_IDLE;
            end

            default: begin
               state     <= ST_DROP;
               no_status <= 1'b0;
            end
         endcase
      end
   end

   eth_bin2gray #(.W(CNT_W)) u_gray_succ (.bin(succ_cnt), .gray(succ_rx_count_gray));
   eth_bin2gray #(.W(CNT_W)) u_gray_of   (.bin(of_cnt),   .gray(buff_OF_count_gray));
   eth_bin2gray #(.W(CNT_W)) u_gray_fcs  (.bin(fcs_cnt),  .gray(fcs_err_count_gray));

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: one RMII (2-bit) and one MII (4-bit) instance.
// Latency: n/a.
// Backpressure: fifo_afull driven per scenario.
module tb_rmii_rx_framer;

   logic REF_CLK = 1'b0;
   always #5 REF_CLK = ~REF_CLK;

   logic        arst_n;
   logic        crs2, afull2, wren2, eod2;
   logic [1:0]  rxd2;
   logic [7:0]  din2;
   logic [15:0] succ2, of2, fcs2;
   logic        crs4, afull4, wren4, eod4;
   logic [3:0]  rxd4;
   logic [7:0]  din4;
   logic [15:0] succ4, of4, fcs4;

   rmii_rx_framer #(.DIN_W(2)) u_dut2 (
      .REF_CLK(REF_CLK), .arst_n(arst_n), .CRS(crs2), .RXD(rxd2), .fifo_afull(afull2),
      .fifo_din(din2), .fifo_wren(wren2), .fifo_EOD_in(eod2),
      .succ_rx_count_gray(succ2), .buff_OF_count_gray(of2), .fcs_err_count_gray(fcs2));

   rmii_rx_framer #(.DIN_W(4)) u_dut4 (
      .REF_CLK(REF_CLK), .arst_n(arst_n), .CRS(crs4), .RXD(rxd4), .fifo_afull(afull4),
      .fifo_din(din4), .fifo_wren(wren4), .fifo_EOD_in(eod4),
      .succ_rx_count_gray(succ4), .buff_OF_count_gray(of4), .fcs_err_count_gray(fcs4));

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] frm[$];
   logic [7:0] dat2_q[$], st2_q[$], dat4_q[$], st4_q[$];

   always @(negedge REF_CLK) begin
      if (wren2) begin
         if (eod2) st2_q.push_back(din2);
         else      dat2_q.push_back(din2);
      end
      if (wren4) begin
         if (eod4) st4_q.push_back(din4);
         else      dat4_q.push_back(din4);
      end
   end

   function automatic logic [15:0] gray(input int v);
      logic [15:0] b;
      b = 16'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Payload of n bytes followed by the Ethernet FCS (complemented CRC, LSB byte first).
   task automatic build_frame(input int n, input int seed);
      logic [31:0] c;
      logic [7:0]  b;
      frm.delete();
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         b = 8'(i * 7 + seed);
         frm.push_back(b);
         c = crc_upd(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
   endtask

   task automatic tick();
      @(posedge REF_CLK);
      #1;
   endtask

   task automatic clear_q();
      dat2_q.delete(); st2_q.delete(); dat4_q.delete(); st4_q.delete();
   endtask

   task automatic send_byte(input int w, input logic [7:0] b);
      if (w == 2) begin
         for (int k = 0; k < 4; k++) begin crs2 = 1'b1; rxd2 = b[2*k +: 2]; tick(); end
      end else begin
         for (int k = 0; k < 2; k++) begin crs4 = 1'b1; rxd4 = b[4*k +: 4]; tick(); end
      end
   endtask

   task automatic idle(input int w, input int n);
      for (int i = 0; i < n; i++) begin
         if (w == 2) begin crs2 = 1'b0; rxd2 = 2'd0; end
         else        begin crs4 = 1'b0; rxd4 = 4'd0; end
         tick();
      end
   endtask

   // afull_at: 1-based data byte at which fifo_afull rises (0 = never); extra: dribble cycles.
   task automatic send_frame(input int w, input int afull_at, input int extra);
      for (int i = 0; i < 7; i++) send_byte(w, 8'h55);
      send_byte(w, 8'hD5);
      for (int i = 0; i < frm.size(); i++) begin
         if (i + 1 == afull_at) begin
            if (w == 2) afull2 = 1'b1; else afull4 = 1'b1;
         end
         send_byte(w, frm[i]);
      end
      for (int e = 0; e < extra; e++) begin
         if (w == 2) begin crs2 = 1'b1; rxd2 = 2'd0; end
         else        begin crs4 = 1'b1; rxd4 = 4'd0; end
         tick();
      end
      idle(w, 6);
      afull2 = 1'b0;
      afull4 = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (wren2 !== 1'b0 || eod2 !== 1'b0 || din2 !== 8'h00) begin
         n_fail++; $display("FAIL reset_fifo2: wren=%b eod=%b din=%h want 0 0 00", wren2, eod2, din2); end
      n_checks++; if (succ2 !== 16'h0 || of2 !== 16'h0 || fcs2 !== 16'h0) begin
         n_fail++; $display("FAIL reset_cnt2: %h %h %h want 0 0 0", succ2, of2, fcs2); end
      n_checks++; if (wren4 !== 1'b0 || eod4 !== 1'b0 || din4 !== 8'h00) begin
         n_fail++; $display("FAIL reset_fifo4: wren=%b eod=%b din=%h want 0 0 00", wren4, eod4, din4); end
      n_checks++; if (succ4 !== 16'h0 || of4 !== 16'h0 || fcs4 !== 16'h0) begin
         n_fail++; $display("FAIL reset_cnt4: %h %h %h want 0 0 0", succ4, of4, fcs4); end
      arst_n = 1'b1;
      idle(2, 3);
      n_checks++; if (wren2 !== 1'b0 || wren4 !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_wren: %b %b want 0 0", wren2, wren4); end
   endtask

   task automatic test_good_frame();
      int bad;
      build_frame(60, 3);
      clear_q();
      send_frame(2, 0, 0);
      n_checks++; if (dat2_q.size() != 64) begin
         n_fail++; $display("FAIL good_writes: got %0d want 64", dat2_q.size()); end
      bad = 0;
      for (int i = 0; i < 64 && i < dat2_q.size(); i++) if (dat2_q[i] !== frm[i]) bad++;
      n_checks++; if (bad != 0) begin
         n_fail++; $display("FAIL good_data: %0d bytes differ want 0", bad); end
      n_checks++; if (st2_q.size() != 1 || st2_q[0] !== 8'hC0) begin
         n_fail++; $display("FAIL good_status: n=%0d st=%h want 1 C0", st2_q.size(),
                            (st2_q.size() > 0) ? st2_q[0] : 8'hxx); end
      n_checks++; if (succ2 !== gray(1) || fcs2 !== gray(0) || of2 !== gray(0)) begin
         n_fail++; $display("FAIL good_cnt: succ=%h fcs=%h of=%h want %h 0 0", succ2, fcs2, of2, gray(1)); end
   endtask

   task automatic test_fcs_error();
      build_frame(60, 3);
      frm[5] = frm[5] ^ 8'h01;
      clear_q();
      send_frame(2, 0, 0);
      n_checks++; if (dat2_q.size() != 64) begin
         n_fail++; $display("FAIL fcs_writes: got %0d want 64", dat2_q.size()); end
      n_checks++; if (st2_q.size() != 1 || st2_q[0] !== 8'h40) begin
         n_fail++; $display("FAIL fcs_status: n=%0d st=%h want 1 40", st2_q.size(),
                            (st2_q.size() > 0) ? st2_q[0] : 8'hxx); end
      n_checks++; if (fcs2 !== gray(1) || succ2 !== gray(1)) begin
         n_fail++; $display("FAIL fcs_cnt: fcs=%h succ=%h want %h %h", fcs2, succ2, gray(1), gray(1)); end
   endtask

   task automatic test_abort();
      build_frame(60, 11);
      clear_q();
      send_frame(2, 10, 0);
      n_checks++; if (dat2_q.size() != 9) begin
         n_fail++; $display("FAIL abort_writes: got %0d want 9", dat2_q.size()); end
      n_checks++; if (st2_q.size() != 1 || st2_q[0] !== 8'h10) begin
         n_fail++; $display("FAIL abort_status: n=%0d st=%h want 1 10", st2_q.size(),
                            (st2_q.size() > 0) ? st2_q[0] : 8'hxx); end
      n_checks++; if (of2 !== gray(1) || fcs2 !== gray(1)) begin
         n_fail++; $display("FAIL abort_cnt: of=%h fcs=%h want %h %h", of2, fcs2, gray(1), gray(1)); end
   endtask

   task automatic test_afull_at_start();
      build_frame(60, 3);
      clear_q();
      afull2 = 1'b1;
      send_frame(2, 0, 0);
      n_checks++; if (dat2_q.size() != 0 || st2_q.size() != 0) begin
         n_fail++; $display("FAIL start_drop_writes: data=%0d status=%0d want 0 0", dat2_q.size(), st2_q.size()); end
      n_checks++; if (of2 !== gray(2) || succ2 !== gray(1)) begin
         n_fail++; $display("FAIL start_drop_cnt: of=%h succ=%h want %h %h", of2, succ2, gray(2), gray(1)); end
   endtask

   task automatic test_mii_short();
      build_frame(36, 5);
      clear_q();
      send_frame(4, 0, 0);
      n_checks++; if (dat4_q.size() != 40) begin
         n_fail++; $display("FAIL mii_short_writes: got %0d want 40", dat4_q.size()); end
      n_checks++; if (st4_q.size() != 1 || st4_q[0] !== 8'h80) begin
         n_fail++; $display("FAIL mii_short_status: n=%0d st=%h want 1 80", st4_q.size(),
                            (st4_q.size() > 0) ? st4_q[0] : 8'hxx); end
      n_checks++; if (succ4 !== gray(0) || fcs4 !== gray(0)) begin
         n_fail++; $display("FAIL mii_short_cnt: succ=%h fcs=%h want 0 0", succ4, fcs4); end
   endtask

   task automatic test_mii_dribble();
      build_frame(60, 9);
      clear_q();
      send_frame(4, 0, 1);
      n_checks++; if (dat4_q.size() != 64) begin
         n_fail++; $display("FAIL dribble_writes: got %0d want 64", dat4_q.size()); end
      n_checks++; if (st4_q.size() != 1 || st4_q[0] !== 8'hE0) begin
         n_fail++; $display("FAIL dribble_status: n=%0d st=%h want 1 E0", st4_q.size(),
                            (st4_q.size() > 0) ? st4_q[0] : 8'hxx); end
      n_checks++; if (succ4 !== gray(0) || fcs4 !== gray(0)) begin
         n_fail++; $display("FAIL dribble_cnt: succ=%h fcs=%h want 0 0", succ4, fcs4); end
   endtask

   task automatic test_reset_midframe();
      int bad;
      build_frame(60, 3);
      clear_q();
      for (int i = 0; i < 7; i++) send_byte(2, 8'h55);
      send_byte(2, 8'hD5);
      for (int i = 0; i < 20; i++) send_byte(2, frm[i]);
      arst_n = 1'b0;
      #1;
      n_checks++; if (wren2 !== 1'b0 || eod2 !== 1'b0 || din2 !== 8'h00) begin
         n_fail++; $display("FAIL midrst_fifo: wren=%b eod=%b din=%h want 0 0 00", wren2, eod2, din2); end
      n_checks++; if (succ2 !== 16'h0 || of2 !== 16'h0 || fcs2 !== 16'h0) begin
         n_fail++; $display("FAIL midrst_cnt: %h %h %h want 0 0 0", succ2, of2, fcs2); end
      tick();
      tick();
      clear_q();
      arst_n = 1'b1;
      // Carrier still up at release: the rest of this frame must be ignored.
      for (int i = 20; i < frm.size(); i++) send_byte(2, frm[i]);
      idle(2, 6);
      n_checks++; if (dat2_q.size() != 0 || st2_q.size() != 0) begin
         n_fail++; $display("FAIL midrst_ignore: data=%0d status=%0d want 0 0", dat2_q.size(), st2_q.size()); end
      clear_q();
      send_frame(2, 0, 0);
      n_checks++; if (dat2_q.size() != 64) begin
         n_fail++; $display("FAIL midrst_next_writes: got %0d want 64", dat2_q.size()); end
      bad = 0;
      for (int i = 0; i < 64 && i < dat2_q.size(); i++) if (dat2_q[i] !== frm[i]) bad++;
      n_checks++; if (bad != 0) begin
         n_fail++; $display("FAIL midrst_next_data: %0d bytes differ want 0", bad); end
      n_checks++; if (st2_q.size() != 1 || st2_q[0] !== 8'hC0) begin
         n_fail++; $display("FAIL midrst_next_status: n=%0d st=%h want 1 C0", st2_q.size(),
                            (st2_q.size() > 0) ? st2_q[0] : 8'hxx); end
      n_checks++; if (succ2 !== gray(1) || of2 !== gray(0) || fcs2 !== gray(0)) begin
         n_fail++; $display("FAIL midrst_next_cnt: succ=%h of=%h fcs=%h want %h 0 0", succ2, of2, fcs2, gray(1)); end
   endtask

   initial begin
      arst_n = 1'b0;
      crs2 = 1'b0; rxd2 = 2'd0; afull2 = 1'b0;
      crs4 = 1'b0; rxd4 = 4'd0; afull4 = 1'b0;
      tick();
      tick();
      test_reset();
      test_good_frame();
      test_fcs_error();
      test_abort();
      test_afull_at_start();
      test_mii_short();
      test_mii_dribble();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
